// File: rtl/cpu_test_sequencer_if.sv
// Handshake bundle between the test sequencer (master) and the lab cpu (slave):
// instruction word, load/s strobes out; result word, {N,V,Z} flags and w back.
interface cpu_test_sequencer_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] dut_in;
  logic              dut_load;
  logic              dut_s;
  logic [DATA_W-1:0] dut_out;
  logic [2:0]        dut_nvz;
  logic              dut_w;

  modport master (
    output dut_in, dut_load, dut_s,
    input  dut_out, dut_nvz, dut_w
  );

  modport slave (
    input  dut_in, dut_load, dut_s,
    output dut_out, dut_nvz, dut_w
  );
endinterface

// File: rtl/cpu_test_sequencer.sv
// Vector-table driver for the lab cpu: issues each stored instruction, waits on w, scores the result.
// Optional macro SEQ_STOP_ON_FAIL_EN: end the run at the first compare mismatch.
module cpu_test_sequencer #(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 16,
  parameter  int TO_CYCLES = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vec_we_i,
  input  logic [AW-1:0]     vec_addr_i,
  input  logic [DATA_W-1:0] vec_instr_i,
  input  logic [DATA_W-1:0] vec_exp_out_i,
  input  logic [2:0]        vec_exp_flags_i,
  input  logic [1:0]        vec_mask_i,
  input  logic [AW:0]       num_vec_i,
  input  logic              start_i,
  cpu_test_sequencer_if.master cpu_if,
  output logic              busy_o,
  output logic              done_o,
  output logic [AW:0]       pass_cnt_o,
  output logic [AW:0]       fail_cnt_o,
  output logic [AW-1:0]     first_fail_o,
  output logic              err_timeout_o
);

  localparam int TO_W = $clog2(TO_CYCLES + 1);
`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_WAIT_ACK, S_WAIT_DONE, S_CHECK, S_DONE
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     idx_q;
  logic [AW:0]       nvec_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [AW:0]       pass_q, fail_q;
  logic [AW-1:0]     ff_q;
  logic              err_q, busy_q, done_q;
  logic [DATA_W-1:0] din_q;
  logic              load_q, s_q;

  logic [DATA_W-1:0] instr_mem   [DEPTH];
  logic [DATA_W-1:0] exp_out_mem [DEPTH];
  logic [2:0]        exp_fl_mem  [DEPTH];
  logic [1:0]        mask_mem    [DEPTH];

  function automatic logic vec_ok(input logic [1:0] mask, input logic [DATA_W-1:0] out,
                                  input logic [DATA_W-1:0] exp_out, input logic [2:0] nvz,
                                  input logic [2:0] exp_fl);
    return (!mask[1] || (out == exp_out)) && (!mask[0] || (nvz == exp_fl));
  endfunction

  logic              accept;
  logic [AW:0]       nvec_d;
  logic [DATA_W-1:0] instr0_d;
  logic [AW-1:0]     idx_d;
  logic              pass_now, last_vec, phase_met, to_hit;

  assign accept    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign nvec_d    = (num_vec_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec_i;
  // A slot-0 write in the same cycle as start must reach the first LOAD.
  assign instr0_d  = (vec_we_i && (vec_addr_i == '0)) ? vec_instr_i : instr_mem[0];
  assign idx_d     = idx_q + AW'(1);
  assign pass_now  = vec_ok(mask_mem[idx_q], cpu_if.dut_out, exp_out_mem[idx_q],
                            cpu_if.dut_nvz, exp_fl_mem[idx_q]);
  assign last_vec  = ({1'b0, idx_q} == (nvec_q - (AW+1)'(1)));
  assign phase_met = (state_q == S_WAIT_ACK) ? !cpu_if.dut_w : cpu_if.dut_w;
  assign to_hit    = (to_cnt_q == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (vec_we_i && accept) begin
      instr_mem[vec_addr_i]   <= vec_instr_i;
      exp_out_mem[vec_addr_i] <= vec_exp_out_i;
      exp_fl_mem[vec_addr_i]  <= vec_exp_flags_i;
      mask_mem[vec_addr_i]    <= vec_mask_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nvec_q   <= '0;
      to_cnt_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ff_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      din_q    <= '0;
      load_q   <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            pass_q <= '0;
            fail_q <= '0;
            ff_q   <= '0;
            err_q  <= 1'b0;
            idx_q  <= '0;
            nvec_q <= nvec_d;
            if (nvec_d == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              din_q   <= instr0_d;
              load_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          load_q  <= 1'b0;
          s_q     <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          s_q      <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_WAIT_ACK;
        end
        S_WAIT_ACK, S_WAIT_DONE: begin
          if (phase_met) begin
            to_cnt_q <= '0;
            state_q  <= (state_q == S_WAIT_ACK) ? S_WAIT_DONE : S_CHECK;
          end else if (to_hit) begin
            fail_q  <= fail_q + (AW+1)'(1);
            if (fail_q == '0) ff_q <= idx_q;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_CHECK: begin
          if (pass_now) begin
            pass_q <= pass_q + (AW+1)'(1);
          end else begin
            fail_q <= fail_q + (AW+1)'(1);
            if (fail_q == '0) ff_q <= idx_q;
          end
          if (last_vec || (STOP_ON_FAIL && !pass_now)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
            din_q   <= instr_mem[idx_d];
            load_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_if.dut_in   = din_q;
  assign cpu_if.dut_load = load_q;
  assign cpu_if.dut_s    = s_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_cnt_o      = pass_q;
  assign fail_cnt_o      = fail_q;
  assign first_fail_o    = ff_q;
  assign err_timeout_o   = err_q;

endmodule
